mem_stage_lsu: RTL and testbench

//  MEM-stage load/store unit between the EX_MEM register and the MEM_WB register.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 46 ++++
 rtl/mem_stage_lsu.sv | 188 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - access-size and FSM encodings plus alignment helpers for the MEM-stage LSU
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } lsu_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } lsu_state_t;

    // Reserved size behaves as a word everywhere, hence the default arms.
    function automatic logic [1:0] lsu_align_off(input lsu_size_t size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return off;
            SIZE_HALF: return {off[1], 1'b0};
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input lsu_size_t size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            default:   return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable/write-data lane steering and load lane extraction with extension
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_t   st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  lsu_size_t   ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [15:0] lane;

    always_comb begin
        be_o    = 4'hF;
        wdata_o = st_data_i;
        case (st_size_i)
            SIZE_BYTE: begin
                be_o    = 4'b0001 << st_off_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            SIZE_HALF: begin
                be_o    = 4'b0011 << {st_off_i[1], 1'b0};
                wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign lane = 16'(rdata_i >> {ld_off_i, 3'b000});

    always_comb begin
        ld_data_o = rdata_i;
        case (ld_size_i)
            SIZE_BYTE: ld_data_o = {{24{lane[7] & ~ld_unsigned_i}}, lane[7:0]};
            SIZE_HALF: ld_data_o = {{16{lane[15] & ~ld_unsigned_i}}, lane[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: req/ack data bus, pipeline stall, timeout fault
// Optional LSU_ALIGN_CHECK_EN: misaligned half/word faults instead of being forced to alignment.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  Size_in,
    input  logic        Unsigned_in,
    input  logic [31:0] ALU_Data_in,
    input  logic [31:0] Store_Data_in,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic [4:0]  Reg_Write_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_out,
    output logic [31:0] Mem_Data_out,
    output logic [31:0] ALU_Data_out,
    output logic        MemtoReg_out,
    output logic        MemRead_out,
    output logic [4:0]  Reg_Write_out,
    output logic        RegWrite_out,
    output logic        mem_fault
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit TO_EN = (TIMEOUT != 0);

    lsu_state_t  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        fault_q, fault_d;
    logic        ld_load_q, ld_load_d;
    lsu_size_t   ld_size_q, ld_size_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic        ld_uns_q, ld_uns_d;

    lsu_size_t   size_w;
    logic [1:0]  off_w;
    logic        mem_op;
    logic        align_fault;
    logic [3:0]  be_w;
    logic [31:0] wdata_w;
    logic [31:0] load_w;

    assign size_w = lsu_size_t'(Size_in);
    assign off_w  = lsu_align_off(size_w, ALU_Data_in[1:0]);
    assign mem_op = MemRead_in | MemWrite_in;

`ifdef LSU_ALIGN_CHECK_EN
    assign align_fault = (state_q == IDLE) && mem_op && lsu_misaligned(size_w, ALU_Data_in[1:0]);
`else
    assign align_fault = 1'b0;
`endif

    lsu_align u_align (
        .st_size_i     (size_w),
        .st_off_i      (off_w),
        .st_data_i     (Store_Data_in),
        .be_o          (be_w),
        .wdata_o       (wdata_w),
        .ld_size_i     (ld_size_q),
        .ld_off_i      (ld_off_q),
        .ld_unsigned_i (ld_uns_q),
        .rdata_i       (dmem_rdata),
        .ld_data_o     (load_w)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        fault_d   = fault_q;
        ld_load_d = ld_load_q;
        ld_size_d = ld_size_q;
        ld_off_d  = ld_off_q;
        ld_uns_d  = ld_uns_q;
        stall_out = 1'b0;
        case (state_q)
            IDLE: begin
                fault_d = 1'b0;
                if (mem_op && !align_fault) begin
                    stall_out = 1'b1;
                    req_d     = 1'b1;
                    we_d      = MemWrite_in;
                    addr_d    = {ALU_Data_in[31:2], 2'b00};
                    be_d      = be_w;
                    wdata_d   = wdata_w;
                    ld_load_d = ~MemWrite_in;
                    ld_size_d = size_w;
                    ld_off_d  = off_w;
                    ld_uns_d  = Unsigned_in;
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                stall_out = 1'b1;
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    data_d  = ld_load_q ? load_w : 32'h0;
                    fault_d = 1'b0;
                    state_d = DONE;
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    data_d  = 32'h0;
                    fault_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // MEM_WB captures this cycle; the frozen EX_MEM advances on the same edge.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            cnt_q     <= '0;
            data_q    <= 32'h0;
            fault_q   <= 1'b0;
            ld_load_q <= 1'b0;
            ld_size_q <= SIZE_BYTE;
            ld_off_q  <= 2'b00;
            ld_uns_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            fault_q   <= fault_d;
            ld_load_q <= ld_load_d;
            ld_size_q <= ld_size_d;
            ld_off_q  <= ld_off_d;
            ld_uns_q  <= ld_uns_d;
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;

    assign mem_fault     = ((state_q == DONE) && fault_q) || align_fault;
    assign Mem_Data_out  = (state_q == DONE) ? data_q : 32'h0;
    assign ALU_Data_out  = ALU_Data_in;
    assign MemtoReg_out  = MemtoReg_in;
    assign MemRead_out   = MemRead_in;
    assign Reg_Write_out = Reg_Write_in;
    assign RegWrite_out  = RegWrite_in & ~mem_fault;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized self-checking bench for mem_stage_lsu against a behavioural model
module tb_mem_stage_lsu;

    localparam int TO = 4;

    bit          clk = 1'b0;
    logic        rst_n;
    logic        MemRead_in, MemWrite_in, Unsigned_in, MemtoReg_in, RegWrite_in;
    logic [1:0]  Size_in;
    logic [31:0] ALU_Data_in, Store_Data_in, dmem_rdata;
    logic [4:0]  Reg_Write_in;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, stall_out, MemtoReg_out, MemRead_out, RegWrite_out, mem_fault;
    logic [31:0] dmem_addr, dmem_wdata, Mem_Data_out, ALU_Data_out;
    logic [3:0]  dmem_be;
    logic [4:0]  Reg_Write_out;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_lsu #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .MemRead_in    (MemRead_in),
        .MemWrite_in   (MemWrite_in),
        .Size_in       (Size_in),
        .Unsigned_in   (Unsigned_in),
        .ALU_Data_in   (ALU_Data_in),
        .Store_Data_in (Store_Data_in),
        .MemtoReg_in   (MemtoReg_in),
        .RegWrite_in   (RegWrite_in),
        .Reg_Write_in  (Reg_Write_in),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .stall_out     (stall_out),
        .Mem_Data_out  (Mem_Data_out),
        .ALU_Data_out  (ALU_Data_out),
        .MemtoReg_out  (MemtoReg_out),
        .MemRead_out   (MemRead_out),
        .Reg_Write_out (Reg_Write_out),
        .RegWrite_out  (RegWrite_out),
        .mem_fault     (mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_be(input int nb, input int off);
        return 32'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] ref_wdata(input int nb, input logic [31:0] sd);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input int nb, input bit uns, input int off, input logic [31:0] rd);
        longint v;
        longint span;
        span = longint'(1) << (8 * nb);
        v = longint'(rd >> (8 * off)) % span;
        if (!uns && nb < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // Present one instruction at a negedge; returns at a negedge after the op has retired.
    // d = BUSY cycle index carrying the ack, negative = never ack (timeout).
    task automatic run_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdv,
                          input int d);
        int  nb, off, stalls;
        bit  memop, afault, tmo, rw, m2r;
        logic [4:0] rwa;
        nb     = nbytes(sz);
        off    = int'(a[1:0]);
        memop  = rd | wr;
        afault = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        afault = memop && (off % nb != 0);
`endif
        off = off - off % nb;
        rw  = 1'($urandom);
        m2r = 1'($urandom);
        rwa = 5'($urandom);
        MemRead_in = rd;  MemWrite_in = wr;  Size_in = sz;  Unsigned_in = uns;
        ALU_Data_in = a;  Store_Data_in = sd;
        MemtoReg_in = m2r; RegWrite_in = rw; Reg_Write_in = rwa;
        dmem_ack = 1'b0;  dmem_rdata = $urandom;
        if (!memop) dmem_ack = 1'($urandom);
        #1;
        chk("alu_pass", ALU_Data_out, a);
        chk("rd_pass", {31'b0, MemRead_out}, {31'b0, rd});
        chk("rwaddr_pass", {27'b0, Reg_Write_out}, {27'b0, rwa});
        if (!memop || afault) begin
            chk("stall_nomem", {31'b0, stall_out}, 32'd0);
            chk("fault_nomem", {31'b0, mem_fault}, {31'b0, afault});
            chk("rw_nomem", {31'b0, RegWrite_out}, {31'b0, rw & ~afault});
            @(posedge clk);
            @(negedge clk);
            chk("no_req", {31'b0, dmem_req}, 32'd0);
            return;
        end
        chk("stall_issue", {31'b0, stall_out}, 32'd1);
        chk("fault_issue", {31'b0, mem_fault}, 32'd0);
        stalls = 1;
        tmo = (d < 0);
        @(posedge clk);
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            chk("req_busy", {31'b0, dmem_req}, 32'd1);
            chk("stall_busy", {31'b0, stall_out}, 32'd1);
            if (k == 0) begin
                chk("we", {31'b0, dmem_we}, {31'b0, wr});
                chk("addr", dmem_addr, {a[31:2], 2'b00});
                chk("be", {28'b0, dmem_be}, ref_be(nb, off));
                chk("wdata", dmem_wdata, ref_wdata(nb, sd));
            end
            stalls++;
            dmem_ack   = (k == d);
            dmem_rdata = (k == d) ? rdv : $urandom;
            @(posedge clk);
            if (k == d) break;
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("stall_done", {31'b0, stall_out}, 32'd0);
        chk("stall_cycles", stalls, tmo ? TO + 1 : d + 2);
        chk("req_done", {31'b0, dmem_req}, 32'd0);
        chk("fault_done", {31'b0, mem_fault}, {31'b0, tmo});
        chk("rw_done", {31'b0, RegWrite_out}, {31'b0, rw & ~tmo});
        chk("m2r_done", {31'b0, MemtoReg_out}, {31'b0, m2r});
        chk("mem_data", Mem_Data_out, (tmo || wr) ? 32'h0 : ref_load(nb, uns, off, rdv));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        MemRead_in = 0; MemWrite_in = 0; Size_in = 0; Unsigned_in = 0;
        ALU_Data_in = 0; Store_Data_in = 0; MemtoReg_in = 0; RegWrite_in = 0;
        Reg_Write_in = 0; dmem_ack = 0; dmem_rdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_we", {31'b0, dmem_we}, 32'd0);
        chk("rst_be", {28'b0, dmem_be}, 32'd0);
        chk("rst_stall", {31'b0, stall_out}, 32'd0);
        chk("rst_fault", {31'b0, mem_fault}, 32'd0);
        chk("rst_data", Mem_Data_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1, 0, 2'd0, 0, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 0);
        run_op(1, 0, 2'd1, 1, 32'h0000_0102, 32'h0, 32'h9234_5678, 0);
        run_op(0, 1, 2'd0, 0, 32'h0000_0201, 32'h1234_5678, 32'h0, 1);
        run_op(1, 0, 2'd2, 0, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, -1);
        run_op(1, 0, 2'd2, 0, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 0);
        run_op(1, 1, 2'd2, 0, 32'h0000_0500, 32'hA5A5_5A5A, 32'h1111_2222, 2);
        run_op(0, 0, 2'd0, 0, 32'h0000_0600, 32'h0, 32'h0, 0);

        // Reset during BUSY, then a stray ack while idle.
        MemRead_in = 1; MemWrite_in = 0; Size_in = 2'd2; ALU_Data_in = 32'h300;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_req", {31'b0, dmem_req}, 32'd1);
        MemRead_in = 0;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'b0, dmem_req}, 32'd0);
        chk("midrst_stall", {31'b0, stall_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h7777_7777;
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("late_ack_req", {31'b0, dmem_req}, 32'd0);
        chk("late_ack_stall", {31'b0, stall_out}, 32'd0);
        chk("late_ack_data", Mem_Data_out, 32'd0);
        run_op(1, 0, 2'd2, 0, 32'h0000_0700, 32'h0, 32'h0BAD_CAFE, 0);
        run_op(1, 0, 2'd0, 0, 32'h0000_0701, 32'h0, 32'h0000_FF00, 0);

        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            run_op(sel inside {[0:4], 8}, sel inside {[5:8]}, 2'($urandom), 1'($urandom),
                   $urandom, $urandom, $urandom,
                   ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO - 1)));
        end
        MemRead_in = 0; MemWrite_in = 0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
